// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, reset/enable levels and constants for the
// MIPS general-purpose register file and its read-port sub-module.
package regfile_pkg;

   localparam int REG_DATA_W   = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int REG_NUM      = 32;
   localparam int REG_NUM_LOG2 = 5;

   localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
   localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic READ_ENABLE   = 1'b1;
   localparam logic READ_DISABLE  = 1'b0;

   // Reset is active-low: the register file is cleared while rst == RST_ACTIVE.
   localparam logic RST_ACTIVE = 1'b0;

   // A write-back request only lands in the array when enabled and not aimed at $0.
   function automatic logic write_accepted(input logic we,
                                           input logic [REG_ADDR_W-1:0] waddr);
      return (we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR);
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: combinational read mux for one register-file port.
// Priority: reset -> $0 -> same-cycle write bypass -> array -> disabled.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
)
(
   input  logic              rst_n,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rdata
);

   // Select the port's read value in strict priority order so every path is defined.
   always_comb begin
      rdata = '0;
      if (rst_n == RST_ACTIVE) begin
         rdata = '0;
      end else if (raddr == '0) begin
         rdata = '0;
      end else if ((re == READ_ENABLE) && (we == WRITE_ENABLE) && (waddr == raddr)) begin
         rdata = wdata;
      end else if (re == READ_ENABLE) begin
         rdata = mem_rdata;
      end else begin
         rdata = '0;
      end
   end

endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32-bit MIPS general-purpose register file with two
// combinational read ports, one synchronous write port, $0 hardwired to
// zero and same-cycle write-to-read bypass.
// Optional macro REGFILE_DBG_PORT_EN adds a third (debug) read port, an
// accepted-write counter and the address of the last accepted write.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REG_DATA_W,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int NUM_REGS = REG_NUM
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_DBG_PORT_EN
   ,
   input  logic [ADDR_W-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [31:0]       dbg_wr_cnt,
   output logic [ADDR_W-1:0] dbg_last_waddr
`endif
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [DATA_W-1:0] mem_d [NUM_REGS];
   logic              wr_accept;

   // Next array contents: only an accepted write (enabled, not $0) changes an entry.
   always_comb begin
      mem_d     = mem_q;
      wr_accept = write_accepted(we, waddr);
      if (wr_accept) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage array: cleared asynchronously on reset, updated on the rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= ZERO_WORD;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_port1 (
      .rst_n     (rst),
      .re        (re1),
      .raddr     (raddr1),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .mem_rdata (mem_q[raddr1]),
      .rdata     (rdata1)
   );

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_port2 (
      .rst_n     (rst),
      .re        (re2),
      .raddr     (raddr2),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .mem_rdata (mem_q[raddr2]),
      .rdata     (rdata2)
   );

`ifdef REGFILE_DBG_PORT_EN
   logic [31:0]       dbg_wr_cnt_q;
   logic [31:0]       dbg_wr_cnt_d;
   logic [ADDR_W-1:0] dbg_last_waddr_q;
   logic [ADDR_W-1:0] dbg_last_waddr_d;

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_port_dbg (
      .rst_n     (rst),
      .re        (READ_ENABLE),
      .raddr     (dbg_raddr),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .mem_rdata (mem_q[dbg_raddr]),
      .rdata     (dbg_rdata)
   );

   // Debug bookkeeping: count accepted writes (free-running wrap) and remember the target.
   always_comb begin
      dbg_wr_cnt_d     = dbg_wr_cnt_q;
      dbg_last_waddr_d = dbg_last_waddr_q;
      if (wr_accept) begin
         dbg_wr_cnt_d     = dbg_wr_cnt_q + 32'd1;
         dbg_last_waddr_d = waddr;
      end
   end

   // Debug registers share the array's asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dbg_wr_cnt_q     <= '0;
         dbg_last_waddr_q <= '0;
      end else begin
         dbg_wr_cnt_q     <= dbg_wr_cnt_d;
         dbg_last_waddr_q <= dbg_last_waddr_d;
      end
   end

   assign dbg_wr_cnt     = dbg_wr_cnt_q;
   assign dbg_last_waddr = dbg_last_waddr_q;
`endif

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: table-driven, scoreboarded bench for the regfile block.
// Inputs change on the falling edge, outputs are sampled 1 time unit later,
// and writes land on the following rising edge.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        re1 = 1'b0;
   logic [4:0]  raddr1 = '0;
   logic [31:0] rdata1;
   logic        re2 = 1'b0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rdata2;
`ifdef REGFILE_DBG_PORT_EN
   logic [4:0]  dbg_raddr = '0;
   logic [31:0] dbg_rdata;
   logic [31:0] dbg_wr_cnt;
   logic [4:0]  dbg_last_waddr;
`endif

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re1;
      logic [4:0]  raddr1;
      logic        re2;
      logic [4:0]  raddr2;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   typedef struct {
      logic [31:0] exp1;
      logic [31:0] exp2;
      string       tag;
   } sb_t;

   vec_t vecs[10];
   sb_t  sbq[$];

   regfile dut (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
`ifdef REGFILE_DBG_PORT_EN
      ,
      .dbg_raddr      (dbg_raddr),
      .dbg_rdata      (dbg_rdata),
      .dbg_wr_cnt     (dbg_wr_cnt),
      .dbg_last_waddr (dbg_last_waddr)
`endif
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic r1, input logic [4:0] a1,
                               input logic r2, input logic [4:0] a2,
                               input logic [31:0] e1, input logic [31:0] e2);
      vec_t v;
      v.we = w; v.waddr = wa; v.wdata = wd;
      v.re1 = r1; v.raddr1 = a1; v.re2 = r2; v.raddr2 = a2;
      v.exp1 = e1; v.exp2 = e2;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v, input string tag);
      we     = v.we;
      waddr  = v.waddr;
      wdata  = v.wdata;
      re1    = v.re1;
      raddr1 = v.raddr1;
      re2    = v.re2;
      raddr2 = v.raddr2;
      sbq.push_back('{exp1: v.exp1, exp2: v.exp2, tag: tag});
   endtask

   task automatic checkOutput();
      sb_t e;
      #1;
      if (sbq.size() == 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
      end else begin
         e = sbq.pop_front();
         check({e.tag, "/rdata1"}, rdata1, e.exp1);
         check({e.tag, "/rdata2"}, rdata2, e.exp2);
      end
   endtask

   // One full cycle: drive at the falling edge, check, let the rising edge write.
   task automatic cycle(input vec_t v, input string tag);
      applyStimulus(v, tag);
      checkOutput();
      @(negedge clk);
   endtask

   initial begin
      // Array starts from a cleared state; writes accumulate down the table.
      vecs[0] = mk(1, 5'd3,  32'hDEADBEEF, 1, 5'd5,  1, 5'd31, 32'h0,        32'h0);
      vecs[1] = mk(0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd3,  32'hDEADBEEF, 32'h0);
      vecs[2] = mk(1, 5'd7,  32'h12345678, 1, 5'd7,  1, 5'd7,  32'h12345678, 32'h12345678);
      vecs[3] = mk(1, 5'd9,  32'hCAFEF00D, 0, 5'd9,  1, 5'd9,  32'h0,        32'hCAFEF00D);
      vecs[4] = mk(1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  1, 5'd7,  32'h0,        32'h12345678);
      vecs[5] = mk(0, 5'd0,  32'h0,        1, 5'd0,  1, 5'd9,  32'h0,        32'hCAFEF00D);
      vecs[6] = mk(1, 5'd3,  32'hA5A5A5A5, 1, 5'd3,  1, 5'd7,  32'hA5A5A5A5, 32'h12345678);
      vecs[7] = mk(0, 5'd0,  32'h0,        1, 5'd3,  1, 5'd31, 32'hA5A5A5A5, 32'h0);
      vecs[8] = mk(1, 5'd31, 32'h80000001, 0, 5'd31, 0, 5'd31, 32'h0,        32'h0);
      vecs[9] = mk(0, 5'd0,  32'h0,        1, 5'd31, 0, 5'd3,  32'h80000001, 32'h0);

      // Reads while reset is held return zero.
      #2;
      applyStimulus(mk(0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd31, 32'h0, 32'h0), "in_reset");
      checkOutput();
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i], $sformatf("vec%0d", i));
      end

      // Fill r1..r4 (each write is also seen through bypass).
      cycle(mk(1, 5'd1, 32'h11, 1, 5'd1, 0, 5'd0, 32'h11, 32'h0), "fill_r1");
      cycle(mk(1, 5'd2, 32'h22, 1, 5'd2, 0, 5'd0, 32'h22, 32'h0), "fill_r2");
      cycle(mk(1, 5'd3, 32'h33, 1, 5'd3, 0, 5'd0, 32'h33, 32'h0), "fill_r3");
      cycle(mk(1, 5'd4, 32'h44, 1, 5'd4, 0, 5'd0, 32'h44, 32'h0), "fill_r4");

      // Read back, then assert reset mid-cycle with a write pending.
      applyStimulus(mk(0, 5'd0, 32'h0, 1, 5'd1, 1, 5'd4, 32'h11, 32'h44), "pre_reset");
      checkOutput();
      #1;
      rst = 1'b0;
      applyStimulus(mk(1, 5'd5, 32'h55, 1, 5'd1, 1, 5'd5, 32'h0, 32'h0), "reset_immediate");
      checkOutput();
      @(posedge clk);
      @(negedge clk);

      // Release mid-cycle with a write ready: the first edge must perform it.
      #2;
      rst = 1'b1;
      applyStimulus(mk(1, 5'd6, 32'h66, 1, 5'd1, 1, 5'd6, 32'h0, 32'h66), "release_bypass");
      checkOutput();
      @(negedge clk);
      cycle(mk(0, 5'd0, 32'h0, 1, 5'd6, 1, 5'd2, 32'h66, 32'h0), "after_rel_r6_r2");
      cycle(mk(0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd4, 32'h0,  32'h0), "after_rel_r3_r4");
      cycle(mk(0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd31, 32'h0, 32'h0), "after_rel_r5_r31");

      // Fresh reset between edges, then three writes, one of them to $0.
      #1;
      rst = 1'b0;
      #1;
      rst = 1'b1;
      @(negedge clk);
`ifdef REGFILE_DBG_PORT_EN
      dbg_raddr = 5'd0;
`endif
      cycle(mk(1, 5'd10, 32'h0A0A0A0A, 1, 5'd10, 0, 5'd0, 32'h0A0A0A0A, 32'h0), "dbg_w10");
      cycle(mk(1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  1, 5'd10, 32'h0, 32'h0A0A0A0A), "dbg_w0");
`ifdef REGFILE_DBG_PORT_EN
      dbg_raddr = 5'd12;
      #1;
      check("dbg_bypass_pre", dbg_rdata, 32'h0);
`endif
      applyStimulus(mk(1, 5'd12, 32'h0C0C0C0C, 0, 5'd12, 1, 5'd12, 32'h0, 32'h0C0C0C0C), "dbg_w12");
      checkOutput();
`ifdef REGFILE_DBG_PORT_EN
      check("dbg_rdata_bypass", dbg_rdata, 32'h0C0C0C0C);
`endif
      @(negedge clk);
      cycle(mk(0, 5'd0, 32'h0, 1, 5'd12, 1, 5'd0, 32'h0C0C0C0C, 32'h0), "dbg_readback");
`ifdef REGFILE_DBG_PORT_EN
      we = 1'b0;
      dbg_raddr = 5'd10;
      #1;
      check("dbg_rdata_r10", dbg_rdata, 32'h0A0A0A0A);
      check("dbg_wr_cnt", dbg_wr_cnt, 32'd2);
      check("dbg_last_waddr", {27'd0, dbg_last_waddr}, 32'd12);
      dbg_raddr = 5'd0;
      #1;
      check("dbg_rdata_r0", dbg_rdata, 32'h0);
`endif

      if (sbq.size() != 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
